// File: rtl/apb_master_bridge_if.sv
// Bus bundle for the APB master bridge: the command side from the control interface
// and the APB side toward the two slaves.
interface apb_master_bridge_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          transfer;
    logic          READ_WRITE;
    logic [AW-1:0] apb_read_paddr;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PSEL1;
    logic          PSEL2;
    logic          PENABLE;
    logic          PREADY;
    logic [DW-1:0] PRDATA1;
    logic [DW-1:0] PRDATA2;
    logic          PSLVERR;
    logic          xfer_done;
    logic          xfer_err;

    modport master (
        input  transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
        input  PREADY, PRDATA1, PRDATA2, PSLVERR,
        output apb_read_data_out, PADDR, PWRITE, PWDATA, PSEL1, PSEL2, PENABLE,
        output xfer_done, xfer_err
    );

    modport slave (
        output transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
        output PREADY, PRDATA1, PRDATA2, PSLVERR,
        input  apb_read_data_out, PADDR, PWRITE, PWDATA, PSEL1, PSEL2, PENABLE,
        input  xfer_done, xfer_err
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master protocol engine: IDLE/SETUP/ACCESS sequencing toward two slaves selected by
// the address MSB, with a bounded PREADY wait and registered completion pulses.
module apb_master_bridge #(
    parameter int AW       = 9,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_master_bridge_if.master    bus
);
    localparam int CW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_waitCnt;
    logic [AW-1:0] r_paddr;
    logic          r_pwrite;
    logic [DW-1:0] r_pwdata;
    logic          r_psel1;
    logic          r_psel2;
    logic          r_penable;
    logic [DW-1:0] r_rdData;
    logic          r_xferDone;
    logic          r_xferErr;

    logic [AW-1:0] w_cmdAddr;
    logic [DW-1:0] w_slaveData;
    logic          w_timeout;

    // Address of the command currently presented; only captured at accept points.
    assign w_cmdAddr   = bus.READ_WRITE ? bus.apb_write_paddr : bus.apb_read_paddr;
    assign w_slaveData = r_paddr[AW-1] ? bus.PRDATA2 : bus.PRDATA1;
    assign w_timeout   = (r_waitCnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_waitCnt  <= '0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_psel1    <= 1'b0;
            r_psel2    <= 1'b0;
            r_penable  <= 1'b0;
            r_rdData   <= '0;
            r_xferDone <= 1'b0;
            r_xferErr  <= 1'b0;
        end else begin
            r_xferDone <= 1'b0;
            r_xferErr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.transfer) begin
                        r_paddr   <= w_cmdAddr;
                        r_pwrite  <= bus.READ_WRITE;
                        r_pwdata  <= bus.apb_write_data;
                        r_psel1   <= ~w_cmdAddr[AW-1];
                        r_psel2   <= w_cmdAddr[AW-1];
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_waitCnt <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over the timeout when both land in the same cycle.
                    if (bus.PREADY) begin
                        r_xferDone <= 1'b1;
                        r_xferErr  <= bus.PSLVERR;
                        r_penable  <= 1'b0;
                        if (!r_pwrite) begin
                            r_rdData <= w_slaveData;
                        end
                        if (bus.transfer) begin
                            r_paddr  <= w_cmdAddr;
                            r_pwrite <= bus.READ_WRITE;
                            r_pwdata <= bus.apb_write_data;
                            r_psel1  <= ~w_cmdAddr[AW-1];
                            r_psel2  <= w_cmdAddr[AW-1];
                            r_state  <= SETUP;
                        end else begin
                            r_psel1 <= 1'b0;
                            r_psel2 <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (w_timeout) begin
                        r_xferDone <= 1'b1;
                        r_xferErr  <= 1'b1;
                        r_penable  <= 1'b0;
                        r_psel1    <= 1'b0;
                        r_psel2    <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + CW'(1);
                    end
                end
                default: begin
                    r_penable <= 1'b0;
                    r_psel1   <= 1'b0;
                    r_psel2   <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.PADDR             = r_paddr;
    assign bus.PWRITE            = r_pwrite;
    assign bus.PWDATA            = r_pwdata;
    assign bus.PSEL1             = r_psel1;
    assign bus.PSEL2             = r_psel2;
    assign bus.PENABLE           = r_penable;
    assign bus.apb_read_data_out = r_rdData;
    assign bus.xfer_done         = r_xferDone;
    assign bus.xfer_err          = r_xferErr;
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Protocol engine that sits directly downstream of the APB master control interface. It consumes the testbench-level command (`transfer`, `READ_WRITE`, read/write addresses, write data) and runs the APB IDLE/SETUP/ACCESS sequence toward two slaves. It decodes address MSB to select slave 1 or 2, waits on PREADY with a bounded timeout, and returns read data on `apb_read_data_out`.

## Interface
Parameters:
- AW, 9, address width; PADDR[AW-1] selects the slave.
- DW, 8, data width.
- MAX_WAIT, 16, max ACCESS cycles without PREADY before abort (≥2).

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- transfer  input  1  command request, sampled at accept points.
- READ_WRITE  input  1  1 = write, 0 = read.
- apb_read_paddr  input  AW  read address.
- apb_write_paddr  input  AW  write address.
- apb_write_data  input  DW  write data.
- apb_read_data_out  output  DW  last completed read data.
- PADDR  output  AW  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  DW  APB write data.
- PSEL1  output  1  select slave 1 (PADDR[AW-1]=0).
- PSEL2  output  1  select slave 2 (PADDR[AW-1]=1).
- PENABLE  output  1  APB enable.
- PREADY  input  1  slave ready, taken from the selected slave.
- PRDATA1, PRDATA2  input  DW  slave read data.
- PSLVERR  input  1  slave error, valid with PREADY.
- xfer_done  output  1  one-cycle pulse on transfer completion (normal or error).
- xfer_err  output  1  one-cycle pulse with xfer_done when PSLVERR=1 or on timeout.

## Operation
- All outputs are registered. Reset values are 0 for PADDR, PWRITE, PWDATA, PSEL1/2, PENABLE, apb_read_data_out, xfer_done, and xfer_err. State resets to IDLE and the wait counter to 0.
- FSM states:
  - IDLE: PSELx=0, PENABLE=0. If transfer=1, latch the command and go to SETUP.
  - SETUP: exactly one cycle. The selected PSELx=1, PENABLE=0. Always go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1. On PREADY=1 the transfer completes: pulse xfer_done, and pulse xfer_err if PSLVERR=1. Then go to SETUP if transfer=1 (new command latched, back-to-back), else go to IDLE.
- Command latch:
  - PADDR = READ_WRITE ? apb_write_paddr : apb_read_paddr.
  - PWRITE = READ_WRITE.
  - PWDATA = apb_write_data. Latched even for reads.
  - These are held constant from SETUP through the end of ACCESS. Inputs changing during SETUP or ACCESS are ignored.
  - After return to IDLE, PADDR, PWRITE and PWDATA retain their last values.
- Slave select is decoded from the latched PADDR[AW-1]. PSEL1 and PSEL2 are never both 1.
- Read completion: apb_read_data_out <= (PADDR[AW-1] ? PRDATA2 : PRDATA1). It is updated even when PSLVERR=1 and holds until the next read completion. Writes never change it.
- Wait counter (width $clog2(MAX_WAIT)+1):
  - Clears on entry to ACCESS.
  - Increments each ACCESS cycle with PREADY=0.
  - When the counter reaches MAX_WAIT-1 with PREADY=0, abort: pulse xfer_done and xfer_err, go to IDLE (transfer is not re-sampled), and leave apb_read_data_out unchanged.
- PREADY=1 in the same cycle the counter hits its limit counts as a normal completion.
- PRESET=1 at any state, including mid-ACCESS: all outputs go to reset values at that edge, and no xfer_done is issued for the aborted transfer.

## Timing
- transfer is sampled only in IDLE, and in ACCESS on the PREADY=1 cycle. transfer=1 in SETUP or during wait states is not acted on.
- Zero-wait transfer: transfer sampled high at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2. With PREADY=1 at edge 3, the FSM leaves ACCESS, and xfer_done plus the updated apb_read_data_out are visible in cycle 3.
- Each wait state adds one cycle.
- Back-to-back transfers: 2 cycles per transfer. PENABLE drops for the one SETUP cycle between transfers, and PSELx stays high if the same slave is selected.
- Timeout: the abort occurs MAX_WAIT ACCESS cycles after ACCESS entry.

## Test plan
- Reset: hold PRESET=1 for 2 cycles with transfer=1 → all outputs 0, state IDLE, no PSEL.
- Read from slave 2 with zero wait: apb_read_paddr=0x1A5, PRDATA2=0x3C, PREADY=1 → PSEL2=1 for 2 cycles, PADDR=0x1A5, apb_read_data_out=0x3C, xfer_done pulse, xfer_err=0.
- Write to slave 1 with 3 wait states: apb_write_paddr=0x045, apb_write_data=0xA7 → PSEL1/PWRITE=1, PWDATA=0xA7 held for 5 cycles, PENABLE=1 for 4 cycles, apb_read_data_out unchanged.
- Back-to-back: write 0x010/0x55 then read 0x110 with transfer held high → second SETUP immediately after the first PREADY, PSEL1→PSEL2 switch, total 4 cycles.
- Error and timeout:
  - PSLVERR=1 with PREADY → xfer_err pulse.
  - PREADY held 0 → abort after 16 ACCESS cycles with xfer_done=xfer_err=1, then return to IDLE.
- Mid-ACCESS reset: assert PRESET during a wait state → next cycle PSELx=PENABLE=0, xfer_done never pulses.
